// File: rtl/tile_buf_pkg.sv
// -----------------------------------------------------------------------------
// tile_buf_pkg
// Shared types and elaboration-time helpers for the tile-gathering SIPO array.
//   slice_w()  : width of one input slice (DATA_W / NUM_GROUPS)
//   cnt_w()    : width of a per-bank fill counter able to hold 0..DEPTH
//   group_of() : which input slice feeds tile channel c
//   bank_state_t : decoded occupancy of one bank
// -----------------------------------------------------------------------------
package tile_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  function automatic int slice_w(input int data_w, input int num_groups);
    return data_w / num_groups;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int group_of(input int c, input int num_tiles, input int num_groups);
    return c / (num_tiles / num_groups);
  endfunction

endpackage

// File: rtl/tile_sipo_lane.sv
// -----------------------------------------------------------------------------
// tile_sipo_lane
// One tile channel: serially gathers DEPTH slices into a bank and presents the
// whole bank in parallel with a pop handshake and a sticky overflow flag.
// Build option: `TILE_PINGPONG_EN gives the channel two banks (A/B) so writing
// continues into the second bank while the first is waiting to be read.
// Ports:
//   clk_i, rst_i   clock (rising edge), asynchronous active-low reset
//   wr_en_i        write strobe for this channel
//   wr_slice_i     slice routed to this channel
//   rd_en_i        pop: consumer accepts the displayed full tile
//   rd_data_o      displayed bank, word k at [k*SLICE_W +: SLICE_W]
//   tile_valid_o   displayed bank holds DEPTH words
//   is_empty_o     no words held in any bank
//   is_full_o      a write this cycle would be dropped (absent a same-cycle pop)
//   overflow_o     sticky: a write was dropped
// -----------------------------------------------------------------------------
module tile_sipo_lane
  import tile_buf_pkg::*;
#(
  parameter int SLICE_W = 64,
  parameter int DEPTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [SLICE_W-1:0]       wr_slice_i,
  input  logic                     rd_en_i,
  output logic [DEPTH*SLICE_W-1:0] rd_data_o,
  output logic                     tile_valid_o,
  output logic                     is_empty_o,
  output logic                     is_full_o,
  output logic                     overflow_o
);

`ifdef TILE_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif
  localparam int            CW       = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Two banks are always declared; without ping-pong both pointers stay at
  // bank 0, so bank 1 is never written and folds away in synthesis.
  logic [SLICE_W-1:0] mem_q [2][DEPTH];
  logic [CW-1:0]      cnt_q [2];
  logic [CW-1:0]      cnt_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               overflow_q;
  bank_state_t        state [2];

  logic               rd_fire;
  logic               release_wr_bank;
  logic               wr_fire;
  logic [CW-1:0]      wr_pos;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      if (cnt_q[b] == '0)            state[b] = EMPTY;
      else if (cnt_q[b] == FULL_CNT) state[b] = FULL;
      else                           state[b] = FILLING;
    end
  end

  // The read pointer always names the oldest bank, so the displayed bank is
  // either the oldest full one or, when none is full, the one being filled.
  assign tile_valid_o = (state[rd_ptr_q] == FULL);
  assign is_full_o    = PINGPONG ? (state[0] == FULL && state[1] == FULL) : tile_valid_o;
  assign is_empty_o   = (state[0] == EMPTY) && (state[1] == EMPTY);
  assign overflow_o   = overflow_q;

  // The write bank is only ever full when every bank is full; in that case it
  // is also the displayed bank, so a same-cycle pop frees it for the write.
  assign rd_fire         = rd_en_i & tile_valid_o;
  assign release_wr_bank = rd_fire & (rd_ptr_q == wr_ptr_q);
  assign wr_fire         = wr_en_i & (~is_full_o | release_wr_bank);

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_pos   = cnt_q[wr_ptr_q];

    if (rd_fire) begin
      cnt_d[rd_ptr_q] = '0;
      if (PINGPONG) rd_ptr_d = ~rd_ptr_q;
    end

    if (release_wr_bank) wr_pos = '0;

    if (wr_fire) begin
      cnt_d[wr_ptr_q] = wr_pos + CW'(1);
      // Hand over to the other bank on the last word, with no dead cycle.
      if (PINGPONG && (wr_pos + CW'(1) == FULL_CNT)) wr_ptr_d = ~wr_ptr_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: storage is reset along with the control state because rd_data_o
      // must read as zero straight out of reset.
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
        for (int k = 0; k < DEPTH; k++) mem_q[b][k] <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_en_i && !wr_fire) overflow_q <= 1'b1;
      // Releasing a bank only clears its count; stale words stay in place.
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (wr_fire && (wr_ptr_q == 1'(b)) && (wr_pos == CW'(k)))
            mem_q[b][k] <= wr_slice_i;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++)
      rd_data_o[k*SLICE_W +: SLICE_W] = mem_q[rd_ptr_q][k];
  end

endmodule

// File: rtl/tile_sipo_array.sv
// -----------------------------------------------------------------------------
// tile_sipo_array
// Tile-gathering SIPO array. The input word is split into NUM_GROUPS equal
// slices; channel c takes slice group_of(c) and gathers DEPTH of them into a
// tile that is presented in parallel to the conv/PE array.
// Build option: `TILE_PINGPONG_EN selects two banks per channel (see lane).
// Ports:
//   clk_i, rst_i   clock (rising edge), asynchronous active-low reset
//   wr_en_i        per-channel write strobe               [NUM_TILES]
//   wr_data_i      input word                             [DATA_W]
//   rd_en_i        per-channel pop                        [NUM_TILES]
//   rd_data_o      word k of tile c at [(c*DEPTH+k)*SLICE_W +: SLICE_W]
//   tile_valid_o   per-channel full tile ready            [NUM_TILES]
//   is_empty_o     per-channel no words held              [NUM_TILES]
//   is_full_o      per-channel cannot accept a write      [NUM_TILES]
//   overflow_o     per-channel sticky dropped-write flag  [NUM_TILES]
// DATA_W and NUM_TILES must both be multiples of NUM_GROUPS; DEPTH >= 2.
// -----------------------------------------------------------------------------
module tile_sipo_array
  import tile_buf_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int NUM_TILES  = 4,
  parameter int NUM_GROUPS = 2,
  parameter int DEPTH      = 4
) (
  input  logic                                                     clk_i,
  input  logic                                                     rst_i,
  input  logic [NUM_TILES-1:0]                                     wr_en_i,
  input  logic [DATA_W-1:0]                                        wr_data_i,
  input  logic [NUM_TILES-1:0]                                     rd_en_i,
  output logic [NUM_TILES*DEPTH*slice_w(DATA_W, NUM_GROUPS)-1:0]   rd_data_o,
  output logic [NUM_TILES-1:0]                                     tile_valid_o,
  output logic [NUM_TILES-1:0]                                     is_empty_o,
  output logic [NUM_TILES-1:0]                                     is_full_o,
  output logic [NUM_TILES-1:0]                                     overflow_o
);

  localparam int SLICE_W = slice_w(DATA_W, NUM_GROUPS);
  localparam int TILE_W  = DEPTH * SLICE_W;

  for (genvar c = 0; c < NUM_TILES; c++) begin : g_lane
    localparam int G = group_of(c, NUM_TILES, NUM_GROUPS);

    tile_sipo_lane #(
      .SLICE_W (SLICE_W),
      .DEPTH   (DEPTH)
    ) u_lane (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_en_i      (wr_en_i[c]),
      .wr_slice_i   (wr_data_i[G*SLICE_W +: SLICE_W]),
      .rd_en_i      (rd_en_i[c]),
      .rd_data_o    (rd_data_o[c*TILE_W +: TILE_W]),
      .tile_valid_o (tile_valid_o[c]),
      .is_empty_o   (is_empty_o[c]),
      .is_full_o    (is_full_o[c]),
      .overflow_o   (overflow_o[c])
    );
  end

endmodule

// File: tb/tb_tile_sipo_array.sv
// -----------------------------------------------------------------------------
// tb_tile_sipo_array
// Self-checking bench for tile_sipo_array (DATA_W=128, 4 tiles, 2 groups,
// DEPTH=4). The reference keeps, per channel, a queue of completed tiles and
// a queue of words of the tile being gathered; flags and displayed words are
// derived from those queues. Honours `TILE_PINGPONG_EN like the design.
// -----------------------------------------------------------------------------
module tb_tile_sipo_array;

  localparam int DATA_W     = 128;
  localparam int NUM_TILES  = 4;
  localparam int NUM_GROUPS = 2;
  localparam int DEPTH      = 4;
  localparam int SLICE_W    = 64;
`ifdef TILE_PINGPONG_EN
  localparam int NUM_BANKS  = 2;
`else
  localparam int NUM_BANKS  = 1;
`endif

  logic                                 clk_i = 1'b0;
  logic                                 rst_i = 1'b1;
  logic [NUM_TILES-1:0]                 wr_en_i = '0;
  logic [DATA_W-1:0]                    wr_data_i = '0;
  logic [NUM_TILES-1:0]                 rd_en_i = '0;
  logic [NUM_TILES*DEPTH*SLICE_W-1:0]   rd_data_o;
  logic [NUM_TILES-1:0]                 tile_valid_o;
  logic [NUM_TILES-1:0]                 is_empty_o;
  logic [NUM_TILES-1:0]                 is_full_o;
  logic [NUM_TILES-1:0]                 overflow_o;

  tile_sipo_array #(
    .DATA_W     (DATA_W),
    .NUM_TILES  (NUM_TILES),
    .NUM_GROUPS (NUM_GROUPS),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (wr_en_i),
    .wr_data_i    (wr_data_i),
    .rd_en_i      (rd_en_i),
    .rd_data_o    (rd_data_o),
    .tile_valid_o (tile_valid_o),
    .is_empty_o   (is_empty_o),
    .is_full_o    (is_full_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference: completed tiles (DEPTH words each, oldest first) and the
  // words of the tile currently being gathered.
  logic [SLICE_W-1:0]   done_q [NUM_TILES][$];
  logic [SLICE_W-1:0]   part_q [NUM_TILES][$];
  logic [NUM_TILES-1:0] ovf_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [SLICE_W-1:0] word(input int c, input int k);
    return rd_data_o[(c*DEPTH+k)*SLICE_W +: SLICE_W];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_TILES; c++) begin
      done_q[c].delete();
      part_q[c].delete();
    end
    ovf_m = '0;
  endtask

  task automatic model_step(input logic [NUM_TILES-1:0] we, input logic [NUM_TILES-1:0] rd,
                            input logic [DATA_W-1:0] data);
    for (int c = 0; c < NUM_TILES; c++) begin
      logic [SLICE_W-1:0] s;
      int  tiles;
      bit  popped;
      s      = (c / (NUM_TILES / NUM_GROUPS) == 0) ? data[63:0] : data[127:64];
      tiles  = done_q[c].size() / DEPTH;
      popped = rd[c] && (tiles > 0);
      if (popped)
        for (int k = 0; k < DEPTH; k++) void'(done_q[c].pop_front());
      if (we[c]) begin
        if (tiles < NUM_BANKS || popped) begin
          part_q[c].push_back(s);
          if (part_q[c].size() == DEPTH) begin
            for (int k = 0; k < DEPTH; k++) done_q[c].push_back(part_q[c][k]);
            part_q[c].delete();
          end
        end else begin
          ovf_m[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_TILES-1:0] e_valid, e_empty, e_full;
    for (int c = 0; c < NUM_TILES; c++) begin
      e_valid[c] = (done_q[c].size() >= DEPTH);
      e_empty[c] = (done_q[c].size() == 0) && (part_q[c].size() == 0);
      e_full[c]  = (done_q[c].size() / DEPTH == NUM_BANKS);
    end
    check($sformatf("%s_valid", tag), 64'(tile_valid_o), 64'(e_valid));
    check($sformatf("%s_empty", tag), 64'(is_empty_o),   64'(e_empty));
    check($sformatf("%s_full",  tag), 64'(is_full_o),    64'(e_full));
    check($sformatf("%s_ovf",   tag), 64'(overflow_o),   64'(ovf_m));
    for (int c = 0; c < NUM_TILES; c++) begin
      if (e_valid[c]) begin
        for (int k = 0; k < DEPTH; k++)
          check($sformatf("%s_c%0d_w%0d", tag, c, k), word(c, k), done_q[c][k]);
      end else begin
        for (int k = 0; k < part_q[c].size(); k++)
          check($sformatf("%s_c%0d_p%0d", tag, c, k), word(c, k), part_q[c][k]);
      end
    end
  endtask

  task automatic step(input logic [NUM_TILES-1:0] we, input logic [NUM_TILES-1:0] rd,
                      input logic [DATA_W-1:0] data, input string tag);
    wr_en_i   = we;
    rd_en_i   = rd;
    wr_data_i = data;
    model_step(we, rd, data);
    @(posedge clk_i);
    #1;
    wr_en_i = '0;
    rd_en_i = '0;
    check_outputs(tag);
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge.
  task automatic apply_reset(input string tag);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    model_reset();
    check($sformatf("%s_rst_valid", tag), 64'(tile_valid_o), 64'h0);
    check($sformatf("%s_rst_empty", tag), 64'(is_empty_o),   64'hF);
    check($sformatf("%s_rst_full",  tag), 64'(is_full_o),    64'h0);
    check($sformatf("%s_rst_ovf",   tag), 64'(overflow_o),   64'h0);
    check($sformatf("%s_rst_data",  tag), 64'(|rd_data_o),   64'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    apply_reset("init");

    // Fill channel 0 from the lower slice.
    for (int i = 0; i < DEPTH; i++)
      step(4'b0001, 4'b0000, {64'h0, 64'hA0 + 64'(i)}, "fill0");
    check("fill0_tv", 64'(tile_valid_o), 64'h1);
    for (int k = 0; k < DEPTH; k++)
      check($sformatf("fill0_word%0d", k), word(0, k), 64'hA0 + 64'(k));

    // Reset while channel 0 holds a full tile.
    apply_reset("mid");

    // Slice routing: channels 0/1 take the low slice, 2/3 the high slice.
    for (int i = 0; i < DEPTH; i++)
      step(4'b1111, 4'b0000, {64'hB, 64'hC}, "route");
    check("route_tv",  64'(tile_valid_o), 64'hF);
    check("route_c1",  word(1, 2), 64'hC);
    check("route_c2",  word(2, 1), 64'hB);

    // Write to channel 1 beyond its capacity with no read.
    apply_reset("ovf");
    for (int i = 0; i < DEPTH; i++)
      step(4'b0010, 4'b0000, {64'h0, 64'h10 + 64'(i)}, "ovf_fill");
    step(4'b0010, 4'b0000, {64'h0, 64'h99}, "ovf_extra");
    step(4'b0000, 4'b0000, '0, "ovf_idle");
`ifdef TILE_PINGPONG_EN
    check("ovf_flag", 64'(overflow_o), 64'h0);
`else
    check("ovf_flag",   64'(overflow_o), 64'h2);
    check("ovf_data",   word(1, 0), 64'h10);
`endif

    // Simultaneous pop and write on a full channel 2.
    apply_reset("rdwr");
    for (int i = 0; i < DEPTH; i++)
      step(4'b0100, 4'b0000, {64'h20 + 64'(i), 64'h0}, "rdwr_fill");
    step(4'b0100, 4'b0100, {64'hD, 64'h0}, "rdwr_both");
    check("rdwr_tv2",    64'(tile_valid_o[2]), 64'h0);
    check("rdwr_empty2", 64'(is_empty_o[2]),   64'h0);
    check("rdwr_word0",  word(2, 0),           64'hD);

    // Eight back-to-back writes into channel 3, then a pop.
    apply_reset("pp");
    for (int i = 0; i < 2*DEPTH; i++)
      step(4'b1000, 4'b0000, {64'h30 + 64'(i), 64'h0}, "pp_fill");
    check("pp_full", 64'(is_full_o[3]), 64'h1);
    step(4'b0000, 4'b1000, '0, "pp_pop");
`ifdef TILE_PINGPONG_EN
    check("pp_full_after", 64'(is_full_o[3]),    64'h0);
    check("pp_tv_after",   64'(tile_valid_o[3]), 64'h1);
    check("pp_bank_b",     word(3, 0),           64'h34);
`else
    check("pp_ovf",        64'(overflow_o[3]),   64'h1);
    check("pp_tv_after",   64'(tile_valid_o[3]), 64'h0);
    check("pp_stale",      word(3, 0),           64'h30);
`endif

    // Randomized traffic, with one reset part-way through.
    apply_reset("rand");
    for (int n = 0; n < 400; n++) begin
      logic [NUM_TILES-1:0] we, rd;
      we = NUM_TILES'($urandom);
      rd = NUM_TILES'($urandom) & NUM_TILES'($urandom);
      if (n == 200) apply_reset("rand_mid");
      step(we, rd, {$urandom, $urandom, $urandom, $urandom}, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
